// File: rtl/f_accum_pkg.sv
// f_accum_pkg: shared definitions for the serial FP accumulator slice.
//   state_t      : accumulator FSM state encoding (IDLE, WAIT, DONE)
//   FP_ZERO      : IEEE-754 single +0.0, the accumulator restart value
//   ADD_WAIT_MIN : shortest operand hold that covers the adder's 4-state period
package f_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] FP_ZERO      = 32'h0000_0000;
  localparam int          ADD_WAIT_MIN = 8;

endpackage

// File: rtl/f_accumseq.sv
// f_accumseq: serial single-precision accumulator, initiator side of the
// f_adderseq operand/sum interface. Each accepted word is presented to the
// adder together with the running sum; the adder result is captured after
// ADD_WAIT cycles. A word flagged last ends the accumulation and the total is
// presented for one cycle.
//   clk18, rst18            : clock, synchronous active-high reset
//   in_valid18/in_ready18   : input word handshake
//   in_data18, in_last18    : IEEE-754 word, end-of-accumulation flag
//   add_a18, add_b18        : adder operands (running sum, latched word)
//   add_sum18               : adder result
//   sum_valid18             : one-cycle pulse, final sum valid
//   sum_out18, count18      : final sum and number of words in it
module f_accumseq
  import f_accum_pkg::*;
#(
  parameter int ADD_WAIT = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk18,
  input  logic             rst18,
  input  logic             in_valid18,
  input  logic [31:0]      in_data18,
  input  logic             in_last18,
  output logic             in_ready18,
  output logic [31:0]      add_a18,
  output logic [31:0]      add_b18,
  input  logic [31:0]      add_sum18,
  output logic             sum_valid18,
  output logic [31:0]      sum_out18,
  output logic [CNT_W-1:0] count18
);

  // A hold shorter than the adder period would sample a stale sum.
  localparam int WAIT_N = (ADD_WAIT < ADD_WAIT_MIN) ? ADD_WAIT_MIN : ADD_WAIT;
  localparam int WCNT_W = $clog2(WAIT_N);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_N - 1);

  state_t            state;
  logic [WCNT_W-1:0] wcnt;
  logic [31:0]       acc;
  logic [31:0]       opnd;
  logic              lastq;
  logic [CNT_W-1:0]  ecnt;

  // Operands come straight from registers, so they stay constant for the
  // whole WAIT state.
  assign add_a18 = acc;
  assign add_b18 = opnd;

  always_ff @(posedge clk18) begin
    if (rst18) begin
      state       <= ST_IDLE;
      wcnt        <= '0;
      acc         <= FP_ZERO;
      opnd        <= FP_ZERO;
      lastq       <= 1'b0;
      ecnt        <= '0;
      in_ready18  <= 1'b1;
      sum_valid18 <= 1'b0;
      sum_out18   <= FP_ZERO;
      count18     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid18 && in_ready18) begin
            opnd       <= in_data18;
            lastq      <= in_last18;
            if (ecnt != '1)
              ecnt <= ecnt + CNT_W'(1);
            wcnt       <= '0;
            in_ready18 <= 1'b0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wcnt == WCNT_LAST) begin
            // Only this cycle's adder output is trusted.
            acc <= add_sum18;
            if (lastq) begin
              sum_out18   <= add_sum18;
              count18     <= ecnt;
              sum_valid18 <= 1'b1;
              state       <= ST_DONE;
            end else begin
              in_ready18 <= 1'b1;
              state      <= ST_IDLE;
            end
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
        end
        ST_DONE: begin
          acc         <= FP_ZERO;
          ecnt        <= '0;
          sum_valid18 <= 1'b0;
          in_ready18  <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          in_ready18  <= 1'b1;
          sum_valid18 <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_f_accumseq.sv
// tb_f_accumseq: directed bench for f_accumseq. The adder is modelled here:
// all stimulus values are multiples of 0.5 with small magnitude, so sums are
// exact and the model works on integer half-units. The model returns garbage
// until its operands have been stable for a few cycles, so an early sample
// shows up as a wrong sum.
module tb_f_accumseq;

  localparam int CNT_W = 16;

  logic             clk18 = 1'b0;
  logic             rst18 = 1'b1;
  logic             in_valid18 = 1'b0;
  logic [31:0]      in_data18 = '0;
  logic             in_last18 = 1'b0;
  logic             in_ready18;
  logic [31:0]      add_a18, add_b18;
  logic [31:0]      add_sum18 = 32'hDEAD_BEEF;
  logic             sum_valid18;
  logic [31:0]      sum_out18;
  logic [CNT_W-1:0] count18;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  f_accumseq #(.ADD_WAIT(8), .CNT_W(CNT_W)) dut (
    .clk18(clk18), .rst18(rst18),
    .in_valid18(in_valid18), .in_data18(in_data18), .in_last18(in_last18),
    .in_ready18(in_ready18),
    .add_a18(add_a18), .add_b18(add_b18), .add_sum18(add_sum18),
    .sum_valid18(sum_valid18), .sum_out18(sum_out18), .count18(count18)
  );

  always #5 clk18 = ~clk18;

  // Value in half-units -> IEEE single.
  function automatic logic [31:0] enc(input int h);
    int m, p;
    logic [31:0] frac;
    if (h == 0) return 32'h0;
    m = (h < 0) ? -h : h;
    p = 0;
    for (int i = 0; i < 24; i++) if ((m >> i) != 0) p = i;
    frac = 32'(m << (23 - p)) & 32'h007F_FFFF;
    return {(h < 0), 8'(126 + p), frac[22:0]};
  endfunction

  // IEEE single -> value in half-units (exact for the values used here).
  function automatic int dec(input logic [31:0] f);
    int e, mant, v;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]);
    mant = int'({9'h001, f[22:0]});
    if (e >= 149) v = mant << (e - 149);
    else          v = mant >> (149 - e);
    return f[31] ? -v : v;
  endfunction

  // Adder model: valid result only after operands held for several cycles.
  logic [63:0] prev_ops = '0;
  int          stab = 0;
  always @(posedge clk18) begin
    if ({add_a18, add_b18} != prev_ops) stab <= 0;
    else if (stab < 15) stab <= stab + 1;
    prev_ops  <= {add_a18, add_b18};
    add_sum18 <= (stab >= 3) ? enc(dec(add_a18) + dec(add_b18)) : 32'hDEAD_BEEF;
  end

  always @(negedge clk18) if (sum_valid18) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one word at a negedge; it is accepted at the following posedge.
  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    @(negedge clk18);
    while (!in_ready18 && n < 40) begin @(negedge clk18); n++; end
    if (n >= 40) check("ready_timeout", 32'(n), 32'(0));
    in_valid18 = 1'b1; in_data18 = d; in_last18 = l;
    @(negedge clk18);
    in_valid18 = 1'b0; in_last18 = 1'b0;
  endtask

  // Wait for the sum pulse; returns negedges waited after the acceptance.
  task automatic wait_sum(output int lat);
    int n = 0;
    while (!sum_valid18 && n < 40) begin @(negedge clk18); n++; end
    if (n >= 40) check("sum_timeout", 32'(n), 32'(0));
    lat = n;
  endtask

  task automatic expect_total(input string tag, input logic [31:0] s, input int c, input int p0);
    int lat;
    wait_sum(lat);
    check({tag, "_sum"}, sum_out18, s);
    check({tag, "_cnt"}, 32'(count18), 32'(c));
    @(negedge clk18);
    check({tag, "_pulse_w"}, 32'(sum_valid18), 32'(0));
    check({tag, "_pulses"}, 32'(pulses - p0), 32'(1));
  endtask

  initial begin
    int lat, p0, acc_h, nw, got, h;

    // Reset state
    repeat (2) @(posedge clk18);
    @(negedge clk18);
    check("rst_ready", 32'(in_ready18), 32'(1));
    check("rst_valid", 32'(sum_valid18), 32'(0));
    check("rst_sum", sum_out18, 32'h0);
    check("rst_cnt", 32'(count18), 32'(0));
    check("rst_add_a", add_a18, 32'h0);
    check("rst_add_b", add_b18, 32'h0);
    rst18 = 1'b0;

    // Single word 1.0: pulse visible 8 negedges after the one following acceptance
    p0 = pulses;
    send(32'h3F80_0000, 1'b1);
    check("wait_ready_low", 32'(in_ready18), 32'(0));
    check("wait_add_b", add_b18, 32'h3F80_0000);
    wait_sum(lat);
    check("single_latency", 32'(lat), 32'(8));
    check("single_sum", sum_out18, 32'h3F80_0000);
    check("single_cnt", 32'(count18), 32'(1));
    @(negedge clk18);
    check("single_pulse_w", 32'(sum_valid18), 32'(0));
    check("single_ready", 32'(in_ready18), 32'(1));
    check("single_hold", sum_out18, 32'h3F80_0000);

    // 1.0 + 2.0
    p0 = pulses;
    send(32'h3F80_0000, 1'b0);
    send(32'h4000_0000, 1'b1);
    expect_total("two", 32'h4040_0000, 2, p0);

    // 1.0 - 1.5, then 1.0 - 1.0 from a fresh accumulator
    p0 = pulses;
    send(32'h3F80_0000, 1'b0);
    send(32'hBFC0_0000, 1'b1);
    expect_total("neg", 32'hBF00_0000, 2, p0);
    p0 = pulses;
    send(32'h3F80_0000, 1'b0);
    send(32'hBF80_0000, 1'b1);
    expect_total("zero", 32'h0000_0000, 2, p0);

    // Valid held high with junk data while not ready
    p0 = pulses;
    got = 0;
    for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
      @(negedge clk18);
      in_valid18 = 1'b1;
      if (in_ready18) begin
        in_data18 = 32'h3F00_0000;
        in_last18 = (got == 3);
        got++;
      end else begin
        in_data18 = $urandom();
        in_last18 = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk18);
    in_valid18 = 1'b0; in_last18 = 1'b0;
    check("held_accepted", 32'(got), 32'(4));
    expect_total("held", 32'h4000_0000, 4, p0);

    // Reset at wcnt=3 of the second word discards the partial sum
    p0 = pulses;
    send(32'h3F80_0000, 1'b0);
    send(32'h3F80_0000, 1'b0);
    repeat (3) @(negedge clk18);
    rst18 = 1'b1;
    @(negedge clk18);
    rst18 = 1'b0;
    check("midrst_pulses", 32'(pulses - p0), 32'(0));
    check("midrst_ready", 32'(in_ready18), 32'(1));
    check("midrst_sum", sum_out18, 32'h0);
    check("midrst_cnt", 32'(count18), 32'(0));
    check("midrst_acc", add_a18, 32'h0);
    p0 = pulses;
    send(32'h4040_0000, 1'b1);
    expect_total("post_rst", 32'h4040_0000, 1, p0);

    // Random stream of 1..20 half-unit values
    for (int r = 0; r < 3; r++) begin
      nw = $urandom_range(1, 20);
      acc_h = 0;
      p0 = pulses;
      for (int i = 0; i < nw; i++) begin
        h = $urandom_range(0, 32) - 16;
        acc_h += h;
        send(enc(h), i == nw - 1);
      end
      expect_total("rand", enc(acc_h), nw, p0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/f_accumseq.md
# f_accumseq

Serial single-precision floating-point accumulator; the initiator side of the `f_adderseq` operand/sum interface. It accepts a stream of IEEE-754 words over a valid/ready handshake and feeds each word, together with the running sum, to an external `f_adderseq`. When the word flagged `in_last18` has been added, it presents the total for one cycle. The block sits between a sample source and the adder inside the `f_accum_top` wrapper.

## Interface
- `ADD_WAIT`, default 8: cycles that operands are held stable before the adder sum is sampled. Must be ≥ 8 to cover the adder's free-running 4-state period.
- `CNT_W`, default 16: width of the element counter.
- `clk18` in 1: clock. One clock domain.
- `rst18` in 1: reset. Synchronous, active-high.
- `in_valid18` in 1: input word valid.
- `in_data18` in 32: IEEE-754 single input word.
- `in_last18` in 1: current word ends the accumulation.
- `in_ready18` out 1: block can accept a word.
- `add_a18` out 32: adder operand A (running sum).
- `add_b18` out 32: adder operand B (latched input word).
- `add_sum18` in 32: adder result.
- `sum_valid18` out 1: one-cycle pulse; final sum valid.
- `sum_out18` out 32: final accumulated sum.
- `count18` out CNT_W: number of words in the finished accumulation.

## Operation
- States:
  - IDLE: `in_ready18`=1.
  - WAIT: `in_ready18`=0; counter `wcnt` runs from 0 to ADD_WAIT−1.
  - DONE: `in_ready18`=0; `sum_valid18`=1.
- IDLE, on `in_valid18 & in_ready18`:
  - latch `in_data18` into `opnd` and `in_last18` into `lastq`;
  - increment `ecnt` (saturates at all-ones);
  - `wcnt`←0; go to WAIT.
- WAIT:
  - `add_a18`=`acc` and `add_b18`=`opnd`, both constant for the whole state.
  - When `wcnt`==ADD_WAIT−1: `acc`←`add_sum18`, then go to DONE if `lastq` is set, else to IDLE.
- DONE, for exactly one cycle:
  - `sum_out18`←`acc` is registered on entry, `count18`←`ecnt` likewise.
  - On exit: `acc`←0x00000000, `ecnt`←0; go to IDLE.
- `acc` starts at +0.0. The first add is therefore x + 0, which the adder returns as x.
- No arithmetic is done in this block. All IEEE handling (sign, alignment, normalize, underflow to zero) belongs to the adder.
- Overflow: `ecnt` saturates. The sum is whatever the adder returns.

## Timing
- Reset values:
  - state IDLE; `in_ready18`=1; `sum_valid18`=0;
  - `sum_out18`=0, `count18`=0, `acc`=0, `opnd`=0, `ecnt`=0;
  - `add_a18`=`add_b18`=0.
- Word accepted at edge E:
  - WAIT spans edges E+1 … E+ADD_WAIT;
  - `acc` updates at edge E+ADD_WAIT;
  - `in_ready18` is high again after edge E+ADD_WAIT.
- Throughput: one word per ADD_WAIT+1 cycles, i.e. 9 with the default.
- Last word accepted at E: `sum_valid18` is high in the cycle after edge E+ADD_WAIT, and the next word can be accepted after edge E+ADD_WAIT+1.
- `in_valid18` held while `in_ready18`=0 is ignored. No word is double-counted, and the source must hold its word.
- `sum_out18` and `count18` hold until the next DONE.
- Reset mid-WAIT or mid-DONE: state returns to IDLE with all reset values and no `sum_valid18` pulse. The partial sum is discarded.
- The sum is sampled only on the last WAIT cycle; `add_sum18` is ignored at all other times.

## Structure
- Shared package `f_accum_pkg`:
  - state encoding localparams (IDLE, WAIT, DONE);
  - `FP_ZERO` = 32'h00000000;
  - `ADD_WAIT_MIN` = 8.
- No sub-module inside `f_accumseq`.
- `f_accum_top` instantiates `f_accumseq` and `f_adderseq` and wires `add_a18`, `add_b18`, `add_sum18`. The adder's `start18` is tied high and its `ready18` is unused.

## Test plan
- Single word 0x3F800000 (1.0) with last → `sum_valid18` 9 cycles after acceptance, `sum_out18`=0x3F800000, `count18`=1.
- 0x3F800000, 0x40000000 (1.0 + 2.0), last on the second → `sum_out18`=0x40400000, `count18`=2, exactly one pulse.
- 0x3F800000, 0xBFC00000 (1.0 − 1.5) → `sum_out18`=0xBF000000; then 0x3F800000, 0xBF800000 → `sum_out18`=0x00000000, confirming `acc` restarts from zero.
- `in_valid18` held high with changing data during WAIT → only words sampled while `in_ready18`=1 are counted; 4 words of 0x3F000000 (0.5) → 0x40000000, `count18`=4.
- `rst18` asserted at `wcnt`=3 of the second word, then the stream 0x40400000 with last → `sum_out18`=0x40400000, `count18`=1, and no pulse before the reset.
- Random in-range stream of 1–20 words compared against a reference model that replays the same adder sequence → bit-exact `sum_out18` and `count18`.
